// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, vector codes and constants for the 6502 cycle sequencer.
package seq_pkg;
    typedef enum logic [1:0] {RST_SEQ = 2'd0, FETCH = 2'd1, EXEC = 2'd2, INT_SEQ = 2'd3} seq_state_t;
    localparam logic [1:0] VEC_NONE = 2'b00;
    localparam logic [1:0] VEC_NMI = 2'b01;
    localparam logic [1:0] VEC_RST = 2'b10;
    localparam logic [1:0] VEC_IRQ = 2'b11;
    localparam int SEQ_LEN_DEF = 7;
    localparam logic [7:0] OP_BRK = 8'h00;
endpackage

// File: rtl/seq_ctrl_if.sv
// seq_ctrl_if: instctrl <-> sequencer handshake (opcode/cycle in, cycle strobes and vector select out).
interface seq_ctrl_if #(parameter int CYC_W = 3);
    logic [7:0] ir;
    logic [CYC_W-1:0] cycle;
    logic irq, nmi, iflag, rdy;
    logic iCyc, sCyc, rCyc, sync, int_ack;
    logic [1:0] vec_sel;
    modport master(input ir, cycle, irq, nmi, iflag, rdy, output iCyc, sCyc, rCyc, sync, vec_sel, int_ack);
    modport slave(output ir, cycle, irq, nmi, iflag, rdy, input iCyc, sCyc, rCyc, sync, vec_sel, int_ack);
endinterface

// File: rtl/seq_len_dec.sv
// seq_len_dec: per-opcode instruction length in cycles (page-crossing penalties not modelled).
module seq_len_dec (
    input  logic [7:0] ir,
    output logic [2:0] len
);
    logic unused_hi;
    assign unused_hi = ^ir[7:5];
    always_comb begin
        len = 3'd2;
        if (ir[1:0] == 2'b01)
            case (ir[4:2])
                3'd0: len = 3'd6;
                3'd1: len = 3'd3;
                3'd2: len = 3'd2;
                3'd4: len = 3'd5;
                default: len = 3'd4;
            endcase
    end
endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: 6502 cycle sequencer driving instctrl strobes, reset/interrupt sequences, NMI/IRQ arbitration.
// Define SEQ_BRK_EN to make opcode 00 (BRK) trap into the IRQ/BRK sequence.
module seq_ctrl import seq_pkg::*; #(
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int CYC_W = 3
) (
    input logic clk,
    input logic rst,
    seq_ctrl_if.master bus
);
    localparam logic [CYC_W-1:0] SEQ_LAST = CYC_W'(SEQ_LEN - 1);
    seq_state_t state, state_nx;
    logic [1:0] vec, vec_nx;
    logic [2:0] len;
    logic [CYC_W-1:0] last;
    logic nmi_q, nmi_pend, nmi_clr, go, trap, at_end;
    seq_len_dec u_dec (.ir(bus.ir), .len(len));
    assign last = CYC_W'(len - 3'd1);
    assign go = bus.rdy & ~rst;
    assign at_end = bus.cycle == last;
`ifdef SEQ_BRK_EN
    assign trap = (bus.ir == OP_BRK) | (bus.irq & ~bus.iflag);
`else
    assign trap = bus.irq & ~bus.iflag;
`endif
    always_comb begin
        state_nx = state;
        vec_nx = vec;
        nmi_clr = 1'b0;
        bus.iCyc = 1'b0;
        bus.sCyc = 1'b0;
        bus.rCyc = 1'b0;
        bus.sync = 1'b0;
        bus.int_ack = 1'b0;
        if (go)
            case (state)
                RST_SEQ, INT_SEQ:
                    if (bus.cycle < SEQ_LAST) bus.iCyc = 1'b1;
                    else begin
                        bus.rCyc = 1'b1;
                        bus.int_ack = 1'b1;
                        state_nx = FETCH;
                        vec_nx = VEC_NONE;
                    end
                FETCH: begin
                    bus.sCyc = 1'b1;
                    bus.iCyc = 1'b1;
                    bus.sync = 1'b1;
                    state_nx = EXEC;
                end
                default:
                    if (bus.cycle < last) bus.iCyc = 1'b1;
                    else begin
                        // an overrun cycle (> last) is a protocol error: just refetch
                        bus.rCyc = 1'b1;
                        state_nx = at_end && (nmi_pend || trap) ? INT_SEQ : FETCH;
                        vec_nx = !at_end ? VEC_NONE : nmi_pend ? VEC_NMI : trap ? VEC_IRQ : VEC_NONE;
                        nmi_clr = at_end & nmi_pend;
                    end
            endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= RST_SEQ;
            vec <= VEC_RST;
            nmi_q <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            state <= state_nx;
            vec <= vec_nx;
            nmi_q <= bus.nmi;
            nmi_pend <= (bus.nmi & ~nmi_q) | (nmi_pend & ~nmi_clr);
        end
    assign bus.vec_sel = vec;
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: closed loop of seq_ctrl with a behavioural instctrl; boundary events scoreboarded per opcode.
module tb_seq_ctrl;
    typedef struct { logic [7:0] op; bit has_int; logic [1:0] vec; } op_t;
    typedef struct { int cyc; bit ack; logic [1:0] vec; } ev_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_err = 0;
    int popped = 0;
    bit after_ack = 1'b0;
    int tbl [8] = '{6, 3, 2, 4, 5, 4, 4, 4};
    op_t prog_q [$];
    ev_t exp_q [$];
    op_t p;
    ev_t e;
    logic [7:0] dec_ir;
    logic [2:0] dec_len;
    seq_ctrl_if #(.CYC_W(3)) bus ();
    seq_ctrl #(.SEQ_LEN(7), .CYC_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    seq_len_dec u_dec (.ir(dec_ir), .len(dec_len));
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int len_of(logic [7:0] op);
        return op[1:0] == 2'b01 ? tbl[op[4:2]] : 2;
    endfunction

    task automatic issue(logic [7:0] op, bit has_int, logic [1:0] vec);
        op_t t;
        t.op = op;
        t.has_int = has_int;
        t.vec = vec;
        prog_q.push_back(t);
    endtask

    task automatic wait_events(int n);
        int tgt = popped + n;
        for (int i = 0; i < 300 && popped < tgt; i++) @(posedge clk) #1;
        chk("event_timeout", popped >= tgt, 1);
    endtask

    task automatic wait_prog(int left);
        for (int i = 0; i < 100 && prog_q.size() > left; i++) @(posedge clk) #1;
        chk("load_timeout", prog_q.size() <= left, 1);
    endtask

    task automatic wait_cycle(logic [2:0] c);
        for (int i = 0; i < 100 && bus.cycle != c; i++) @(posedge clk) #1;
        chk("cycle_timeout", bus.cycle, c);
    endtask

    task automatic pulse_nmi();
        bus.nmi = 1'b1;
        @(posedge clk) #1;
        bus.nmi = 1'b0;
    endtask

    // instctrl model: cycle counter and IR, fed from the program queue on sCyc
    always @(posedge clk or posedge rst)
        if (rst) begin
            bus.cycle <= 3'd0;
            bus.ir <= 8'hEA;
        end else begin
            if (bus.rCyc) bus.cycle <= 3'd0;
            else if (bus.iCyc) bus.cycle <= bus.cycle + 3'd1;
            if (bus.sCyc) begin
                if (prog_q.size() > 0) begin
                    p = prog_q.pop_front();
                    bus.ir <= p.op;
                    exp_q.push_back('{len_of(p.op) - 1, 1'b0, 2'b00});
                    if (p.has_int) exp_q.push_back('{6, 1'b1, p.vec});
                end else bus.ir <= 8'hEA;
            end
        end

    always @(negedge clk)
        if (!rst) begin
            if (after_ack) begin
                chk("fetch_sync_scyc", {bus.sync, bus.sCyc}, 2'b11);
                after_ack = 1'b0;
            end
            if (bus.rCyc) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rcyc_cycle", bus.cycle, e.cyc);
                    chk("int_ack", bus.int_ack, e.ack);
                    chk("vec_sel", bus.vec_sel, e.vec);
                    popped++;
                end else begin
                    chk("pad_cycle", bus.cycle, 1);
                    chk("pad_int_ack", bus.int_ack, 0);
                    chk("pad_vec_sel", bus.vec_sel, 0);
                end
                after_ack = bus.int_ack;
            end else if (bus.int_ack) chk("stray_int_ack", bus.int_ack, 0);
        end

    initial begin
        bus.rdy = 1'b1;
        bus.irq = 1'b0;
        bus.nmi = 1'b0;
        bus.iflag = 1'b1;
        for (int b = 0; b < 8; b++) begin
            dec_ir = {3'b101, 3'(b), 2'b01};
            #1 chk("len_dec_cc01", dec_len, tbl[b]);
        end
        dec_ir = 8'h00;
        #1 chk("len_dec_brk", dec_len, 2);
        dec_ir = 8'hBE;
        #1 chk("len_dec_other", dec_len, 2);
        exp_q.push_back('{6, 1'b1, 2'b10});
        repeat (2) @(posedge clk);
        #1 chk("rst_vec_sel", bus.vec_sel, 2'b10);
        chk("rst_strobes", {bus.iCyc, bus.sCyc, bus.rCyc, bus.sync, bus.int_ack}, 0);
        rst = 1'b0;
        @(negedge clk) chk("rst_seq_icyc", bus.iCyc, 1);
        issue(8'hA9, 0, 2'b00);
        issue(8'hAD, 0, 2'b00);
        issue(8'hB1, 0, 2'b00);
        issue(8'hEA, 0, 2'b00);
        wait_events(5);
        // stall mid-instruction
        issue(8'hAD, 0, 2'b00);
        wait_prog(0);
        wait_cycle(3'd2);
        bus.rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_strobes", {bus.iCyc, bus.sCyc, bus.rCyc, bus.sync, bus.int_ack}, 0);
            chk("stall_cycle", bus.cycle, 2);
        end
        @(posedge clk) #1;
        bus.rdy = 1'b1;
        wait_events(1);
        // masked irq
        issue(8'hAD, 0, 2'b00);
        wait_prog(0);
        bus.irq = 1'b1;
        wait_events(1);
        repeat (6) @(posedge clk);
        #1 bus.irq = 1'b0;
        // unmasked irq
        issue(8'hAD, 1, 2'b11);
        wait_prog(0);
        bus.iflag = 1'b0;
        bus.irq = 1'b1;
        wait_events(2);
        bus.irq = 1'b0;
        // nmi beats irq; second edge mid-sequence waits one instruction
        issue(8'hAD, 1, 2'b01);
        issue(8'hEA, 1, 2'b01);
        wait_prog(1);
        bus.irq = 1'b1;
        pulse_nmi();
        wait_events(1);
        bus.irq = 1'b0;
        repeat (2) @(posedge clk);
        #1 pulse_nmi();
        wait_events(3);
        // async reset mid-sequence discards a pending nmi
        issue(8'hAD, 1, 2'b11);
        wait_prog(0);
        bus.irq = 1'b1;
        wait_events(1);
        bus.irq = 1'b0;
        pulse_nmi();
        wait_cycle(3'd3);
        rst = 1'b1;
        exp_q.delete();
        prog_q.delete();
        after_ack = 1'b0;
        #1 chk("async_rst_vec_sel", bus.vec_sel, 2'b10);
        chk("async_rst_strobes", {bus.iCyc, bus.sCyc, bus.rCyc, bus.sync, bus.int_ack}, 0);
        repeat (2) @(posedge clk);
        #1 exp_q.push_back('{6, 1'b1, 2'b10});
        rst = 1'b0;
        issue(8'hEA, 0, 2'b00);
        wait_events(2);
`ifdef SEQ_BRK_EN
        bus.iflag = 1'b1;
        issue(8'h00, 1, 2'b11);
        wait_events(2);
`else
        issue(8'h00, 0, 2'b00);
        wait_events(1);
`endif
        repeat (8) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
